// File: rtl/poly_mod_addsub.sv
// Streaming multi-lane Kyber coefficient adder/subtractor mod Q with a start/done frame controller.
// Two pipeline stages (raw sum/difference, then conditional correction by Q), frozen together on output stall.
module poly_mod_addsub #(
   parameter int DATA_WID = 12,
   parameter int Q        = 3329,
   parameter int LANES    = 4,
   parameter int N_COEFF  = 256
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      mode,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DATA_WID-1:0] in_a,
   input  logic [LANES*DATA_WID-1:0] in_b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*DATA_WID-1:0] out_data,
   output logic                      out_last,
   output logic                      busy,
   output logic                      done,
   output logic [1:0]                dbg_state
);

   localparam int BEATS = N_COEFF / LANES;
   localparam int CNT_W = $clog2(BEATS + 1);
   localparam int SW    = DATA_WID + 1;
   localparam int W     = LANES * DATA_WID;
   localparam logic [SW-1:0]       Q_S     = SW'(Q);
   localparam logic [DATA_WID-1:0] Q_D     = DATA_WID'(Q);
   localparam logic [CNT_W-1:0]    BEATS_C = CNT_W'(BEATS);
   localparam logic [CNT_W-1:0]    LAST_C  = CNT_W'(BEATS - 1);

   // Handshake: a beat moves on a rising edge where valid && ready; an offered
   // output beat holds out_data/out_last until out_ready takes it.
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic               mode_q, mode_d;
   logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
   logic               s1_valid_q, s1_valid_d;
   logic [SW-1:0]      s1_sum_q [LANES];
   logic [SW-1:0]      s1_sum_d [LANES];
   logic               out_valid_q, out_valid_d;
   logic [W-1:0]       out_data_q, out_data_d;
   logic               stall, in_fire, out_fire;

   // Sub mode keeps the carry of a + ~b + 1; a clear carry means a borrow.
   function automatic logic [SW-1:0] stage1(input logic m,
                                            input logic [DATA_WID-1:0] a,
                                            input logic [DATA_WID-1:0] b);
      if (m) return {1'b0, a} + {1'b0, ~b} + SW'(1);
      return {1'b0, a} + {1'b0, b};
   endfunction

   function automatic logic [DATA_WID-1:0] stage2(input logic m, input logic [SW-1:0] s);
      logic [SW-1:0] t;
      if (m) begin
         if (!s[DATA_WID]) return s[DATA_WID-1:0] + Q_D;
         return s[DATA_WID-1:0];
      end
      t = (s >= Q_S) ? (s - Q_S) : s;
      return t[DATA_WID-1:0];
   endfunction

   assign stall     = out_valid_q && !out_ready;
   assign in_ready  = (state_q == S_RUN) && (in_cnt_q < BEATS_C) && !stall;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid_q && out_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_valid_q && (out_cnt_q == LAST_C);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign dbg_state = state_q;

   always_comb begin
      s1_valid_d  = stall ? s1_valid_q : in_fire;
      out_valid_d = stall ? out_valid_q : s1_valid_q;
      out_data_d  = out_data_q;
      for (int k = 0; k < LANES; k++) begin
         s1_sum_d[k] = s1_sum_q[k];
         if (in_fire)
            s1_sum_d[k] = stage1(mode_q, in_a[k*DATA_WID +: DATA_WID], in_b[k*DATA_WID +: DATA_WID]);
         if (!stall && s1_valid_q)
            out_data_d[k*DATA_WID +: DATA_WID] = stage2(mode_q, s1_sum_q[k]);
      end
   end

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      in_cnt_d  = in_fire  ? in_cnt_q + CNT_W'(1)  : in_cnt_q;
      out_cnt_d = out_fire ? out_cnt_q + CNT_W'(1) : out_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_RUN;
               mode_d    = mode;
               in_cnt_d  = '0;
               out_cnt_d = '0;
            end
         end
         S_RUN:   if (in_cnt_q == BEATS_C) state_d = S_DRAIN;
         S_DRAIN: if (out_fire && out_cnt_q == LAST_C) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mode_q      <= 1'b0;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int k = 0; k < LANES; k++) s1_sum_q[k] <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         for (int k = 0; k < LANES; k++) s1_sum_q[k] <= s1_sum_d[k];
      end
   end

endmodule
